// File: rtl/regbank_wb_arbiter.sv
// Round-robin write-back arbiter for the 16 x 16-bit register bank.
// Grants one producer per cycle and registers its write onto the bank's shared write port.
module regbank_wb_arbiter #(
    parameter int          NREQ      = 3,
    parameter logic [15:0] LOCK_MASK = 16'h0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [4*NREQ-1:0]    req_addr,
    input  logic [16*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [15:0]          ALUBus,
    output logic [15:0]          regEnable,
    output logic                 wb_valid,
    output logic [3:0]           wb_addr,
    output logic [NREQ-1:0]      wb_src,
    output logic                 lock_err
);

    logic [1:0]      ptr_r;
    logic [1:0]      grant_idx_s;
    logic [1:0]      next_ptr_s;
    logic [2:0]      cand_s;
    logic            found_s;
    logic [NREQ-1:0] grant_s;
    logic [15:0]     sel_data_s;
    logic [3:0]      sel_addr_s;
    logic            locked_s;

    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

    // Round-robin search starting at ptr_r; no grant during stall or reset.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = 2'd0;
        found_s     = 1'b0;
        cand_s      = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s = (({1'b0, ptr_r} + 3'(i)) >= 3'(NREQ)) ?
                     ({1'b0, ptr_r} + 3'(i) - 3'(NREQ)) : ({1'b0, ptr_r} + 3'(i));
            if (!found_s && req_valid[cand_s[1:0]] && !stall && reset) begin
                found_s     = 1'b1;
                grant_idx_s = cand_s[1:0];
            end else begin
                found_s     = found_s;
            end
        end
        if (found_s) begin
            grant_s[grant_idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    // Steer the winner's address/data and precompute the pointer advance.
    always_comb begin
        sel_data_s = 16'h0000;
        sel_addr_s = 4'h0;
        for (int k = 0; k < NREQ; k++) begin
            sel_data_s = sel_data_s | (req_data[16*k +: 16] & {16{grant_s[k]}});
            sel_addr_s = sel_addr_s | (req_addr[4*k +: 4] & {4{grant_s[k]}});
        end
        locked_s   = LOCK_MASK[sel_addr_s];
        next_ptr_s = (grant_idx_s == 2'(NREQ - 1)) ? 2'd0 : (grant_idx_s + 2'd1);
    end

    assign req_ready = grant_s;

    // Output stage and pointer; a locked write still consumes the grant but never enables the bank.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_r     <= 2'd0;
            ALUBus    <= 16'h0000;
            regEnable <= 16'h0000;
            wb_valid  <= 1'b0;
            wb_addr   <= 4'h0;
            wb_src    <= '0;
            lock_err  <= 1'b0;
        end else if (found_s) begin
            ptr_r     <= next_ptr_s;
            ALUBus    <= sel_data_s;
            wb_addr   <= sel_addr_s;
            wb_src    <= grant_s;
            wb_valid  <= 1'b1;
            regEnable <= locked_s ? 16'h0000 : onehot16(sel_addr_s);
            lock_err  <= locked_s;
        end else begin
            regEnable <= 16'h0000;
            wb_valid  <= 1'b0;
            lock_err  <= 1'b0;
        end
    end

endmodule
